// File: rtl/dht11_responder.sv
// DHT11 sensor-side emulator: detects the host start pulse on the open-drain
// data line, then answers with the 80/80 us preamble and a 40-bit frame
// {hum_int, hum_dec, temp_int, temp_dec, checksum}. The line is only ever
// pulled low or released; the high level comes from the board pull-up.
//
// Bus handshake: there is no valid/ready pair here. The host owns the line
// until it releases it after a long enough low pulse; from then until
// frame_done the responder owns it (busy=1), and any low seen on the line in
// that window is ignored. Only rst aborts a frame in flight.
module dht11_responder #(
    parameter int CLKS_PER_US  = 100,
    parameter int START_MIN_US = 18000,
    parameter int RESP_DLY_US  = 30,
    parameter int RESP_US      = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int ZERO_HIGH_US = 26,
    parameter int ONE_HIGH_US  = 70
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        data,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] o_dbg_state
);

    // Start threshold in clock cycles; the shared counter is sized for it.
    localparam int START_CYC = START_MIN_US * CLKS_PER_US;
    localparam int CW        = $clog2(START_CYC + 1);

    // Down-counter load values: a timed state of N cycles is entered with N-1
    // and left on the cycle the counter reads zero, so it lasts exactly N.
    localparam logic [CW-1:0] START_LAST   = CW'(START_CYC - 1);
    localparam logic [CW-1:0] DLY_LOAD     = CW'(RESP_DLY_US * CLKS_PER_US - 1);
    localparam logic [CW-1:0] RESP_LOAD    = CW'(RESP_US * CLKS_PER_US - 1);
    localparam logic [CW-1:0] BITLOW_LOAD  = CW'(BIT_LOW_US * CLKS_PER_US - 1);
    localparam logic [CW-1:0] ZERO_LOAD    = CW'(ZERO_HIGH_US * CLKS_PER_US - 1);
    localparam logic [CW-1:0] ONE_LOAD     = CW'(ONE_HIGH_US * CLKS_PER_US - 1);
    localparam logic [5:0]    LAST_BIT     = 6'd39;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HOST_LOW  = 4'd1,
        S_WAIT_REL  = 4'd2,
        S_RESP_DLY  = 4'd3,
        S_RESP_LOW  = 4'd4,
        S_RESP_HIGH = 4'd5,
        S_BIT_LOW   = 4'd6,
        S_BIT_HIGH  = 4'd7,
        S_END_LOW   = 4'd8
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [39:0]   r_frame;
    logic [39:0]   w_frame_nxt;
    logic [5:0]    r_bit_idx;
    logic [5:0]    w_bit_idx_nxt;
    logic          r_armed;
    logic          w_armed_nxt;
    logic          r_frame_done;
    logic          w_done_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_data_s;
    logic          w_cnt_zero;
    logic          w_drive_low;
    logic [7:0]    w_chk;

    assign w_data_s   = r_sync2;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_chk      = hum_int + hum_dec + temp_int + temp_dec;

    // Open-drain output: pull low in the driven slots, otherwise release.
    assign data        = w_drive_low ? 1'b0 : 1'bz;
    assign frame_done  = r_frame_done;
    assign o_dbg_state = r_state;

    // Two-flop synchronizer for the asynchronous bus level (idle level is high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= data;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state, counter, frame shifter and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_frame_nxt   = r_frame;
        w_bit_idx_nxt = r_bit_idx;
        w_armed_nxt   = r_armed;
        w_done_nxt    = 1'b0;
        w_drive_low   = 1'b0;
        busy          = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A start is only considered once the line has been seen
                // high, so our own end low cannot look like a new request.
                if (w_data_s) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_state_nxt = S_HOST_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            S_HOST_LOW: begin
                if (w_data_s) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == START_LAST) begin
                    w_state_nxt = S_WAIT_REL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT_REL: begin
                busy = 1'b1;
                if (w_data_s) begin
                    w_frame_nxt = {hum_int, hum_dec, temp_int, temp_dec, w_chk};
                    w_state_nxt = S_RESP_DLY;
                    w_cnt_nxt   = DLY_LOAD;
                end
            end
            S_RESP_DLY: begin
                busy = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt = S_RESP_LOW;
                    w_cnt_nxt   = RESP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RESP_LOW: begin
                busy        = 1'b1;
                w_drive_low = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt = S_RESP_HIGH;
                    w_cnt_nxt   = RESP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RESP_HIGH: begin
                busy = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt   = S_BIT_LOW;
                    w_cnt_nxt     = BITLOW_LOAD;
                    w_bit_idx_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_BIT_LOW: begin
                busy        = 1'b1;
                w_drive_low = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt = S_BIT_HIGH;
                    w_cnt_nxt   = r_frame[39] ? ONE_LOAD : ZERO_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_BIT_HIGH: begin
                busy = 1'b1;
                if (w_cnt_zero) begin
                    w_cnt_nxt = BITLOW_LOAD;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = S_END_LOW;
                    end else begin
                        w_state_nxt   = S_BIT_LOW;
                        w_bit_idx_nxt = r_bit_idx + 6'd1;
                        w_frame_nxt   = {r_frame[38:0], 1'b0};
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_END_LOW: begin
                busy        = 1'b1;
                w_drive_low = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_armed_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register; reset releases the line immediately via the decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter, frame shifter, bit index, re-arm flag and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_frame      <= '0;
            r_bit_idx    <= '0;
            r_armed      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_frame      <= w_frame_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_armed      <= w_armed_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

endmodule
